// File: rtl/uart_bank_v2.sv
`default_nettype none
// uart_bank_v2: UART CSR bank with req/ack handshake, pop-and-wait RXDATA reads,
// line control, sticky W1C error flags, FIFO level readback and a registered interrupt.
module uart_bank_v2 #(
   parameter int FIFO_DEPTH    = 8,
   parameter int CLOCK_FREQ_HZ = 10000000,
   parameter int BAUD_INIT     = 115200,
   parameter int DIV_WIDTH     = 16,
   localparam int CW           = $clog2(FIFO_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 we,
   input  logic [3:0]           addr,
   input  logic [31:0]          wr_data,
   output logic [31:0]          rd_data,
   output logic                 ack,
   output logic                 interrupt,
   output logic                 txen,
   output logic                 rxen,
   output logic                 nstop,
   output logic                 parity_en,
   output logic                 parity_odd,
   output logic [DIV_WIDTH-1:0] div,
   output logic [CW-1:0]        txcnt,
   output logic [CW-1:0]        rxcnt,
   output logic                 tx_push,
   output logic [7:0]           tx_data,
   input  logic                 tx_full,
   input  logic [CW:0]          tx_level,
   output logic                 rx_pop,
   input  logic [7:0]           rx_data,
   input  logic                 rx_empty,
   input  logic [CW:0]          rx_level,
   input  logic                 rx_frame_err,
   input  logic                 rx_parity_err,
   input  logic                 rx_overrun
);

   // Divisor is rounded to the nearest integer ratio before the -1 (86 at 10 MHz / 115200).
   localparam int                 DIV_RESET_INT = (CLOCK_FREQ_HZ + BAUD_INIT / 2) / BAUD_INIT - 1;
   localparam logic [DIV_WIDTH-1:0] DIV_RESET   = DIV_RESET_INT[DIV_WIDTH-1:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_WAIT = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  txen_q, txen_d, nstop_q, nstop_d, rxen_q, rxen_d;
   logic [CW-1:0]         txcnt_q, txcnt_d, rxcnt_q, rxcnt_d;
   logic [2:0]            ie_q, ie_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [1:0]            lcr_q, lcr_d;
   logic [3:0]            err_q, err_d, err_set, err_clr;
   logic                  push_pend_q, push_pend_d;
   logic [7:0]            pend_data_q, pend_data_d;
   logic [31:0]           rd_hold_q, rd_hold_d;
   logic                  ack_q, ack_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic                  tx_push_q, tx_push_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  rx_pop_q, rx_pop_d;
   logic                  irq_q, irq_d;
   logic [2:0]            ip;
   logic [31:0]           rd_word;
   logic                  unused_wr_bits;

   assign unused_wr_bits = ^wr_data;

   assign ip[0] = tx_level < {1'b0, txcnt_q};
   assign ip[1] = rx_level > {1'b0, rxcnt_q};
   assign ip[2] = |err_q;

   always_comb begin
      rd_word = '0;
      case (addr)
         4'd0: rd_word[31] = tx_full;
         4'd1: rd_word[31] = rx_empty;
         4'd2: begin
            rd_word[16 +: CW] = txcnt_q;
            rd_word[1]        = nstop_q;
            rd_word[0]        = txen_q;
         end
         4'd3: begin
            rd_word[16 +: CW] = rxcnt_q;
            rd_word[0]        = rxen_q;
         end
         4'd4: rd_word[2:0] = ie_q;
         4'd5: rd_word[2:0] = ip;
         4'd6: rd_word[DIV_WIDTH-1:0] = div_q;
         4'd7: rd_word[1:0] = lcr_q;
         4'd8: rd_word[3:0] = err_q;
         4'd9: begin
            rd_word[16 +: CW+1] = rx_level;
            rd_word[0 +: CW+1]  = tx_level;
         end
         default: rd_word = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      txen_d      = txen_q;
      nstop_d     = nstop_q;
      rxen_d      = rxen_q;
      txcnt_d     = txcnt_q;
      rxcnt_d     = rxcnt_q;
      ie_d        = ie_q;
      div_d       = div_q;
      lcr_d       = lcr_q;
      push_pend_d = push_pend_q;
      pend_data_d = pend_data_q;
      rd_hold_d   = rd_hold_q;
      ack_d       = 1'b0;
      rd_data_d   = '0;
      tx_push_d   = 1'b0;
      tx_data_d   = tx_data_q;
      rx_pop_d    = 1'b0;
      err_set     = {1'b0, rx_overrun, rx_parity_err, rx_frame_err};
      err_clr     = '0;

      case (state_q)
         ST_IDLE: begin
            // ack_q high means this is the ACK->IDLE cycle; the current req is already served.
            if (req && !ack_q) begin
               rd_hold_d = rd_word;
               if (!we && addr == 4'd1 && !rx_empty) begin
                  state_d  = ST_POP;
                  rx_pop_d = 1'b1;
               end else begin
                  state_d = ST_ACK;
                  if (we) begin
                     case (addr)
                        4'd0: begin
                           if (tx_full) begin
                              err_set[3] = 1'b1;
                           end else begin
                              push_pend_d = 1'b1;
                              pend_data_d = wr_data[7:0];
                           end
                        end
                        4'd2: begin
                           txcnt_d = wr_data[16 +: CW];
                           nstop_d = wr_data[1];
                           txen_d  = wr_data[0];
                        end
                        4'd3: begin
                           rxcnt_d = wr_data[16 +: CW];
                           rxen_d  = wr_data[0];
                        end
                        4'd4: ie_d = wr_data[2:0];
                        4'd6: begin
                           if (wr_data[DIV_WIDTH-1:0] != '0) div_d = wr_data[DIV_WIDTH-1:0];
                        end
                        4'd7: lcr_d   = wr_data[1:0];
                        4'd8: err_clr = wr_data[3:0];
                        default: ;
                     endcase
                  end
               end
            end
         end
         ST_POP:  state_d = ST_WAIT;
         ST_WAIT: begin
            rd_hold_d = {24'b0, rx_data};
            state_d   = ST_ACK;
         end
         ST_ACK: begin
            state_d   = ST_IDLE;
            ack_d     = 1'b1;
            rd_data_d = rd_hold_q;
            if (push_pend_q) begin
               tx_push_d   = 1'b1;
               tx_data_d   = pend_data_q;
               push_pend_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      err_d = (err_q & ~err_clr) | err_set;
      irq_d = |(ip & ie_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         txen_q      <= 1'b0;
         nstop_q     <= 1'b0;
         rxen_q      <= 1'b0;
         txcnt_q     <= '0;
         rxcnt_q     <= '0;
         ie_q        <= '0;
         div_q       <= DIV_RESET;
         lcr_q       <= '0;
         err_q       <= '0;
         push_pend_q <= 1'b0;
         pend_data_q <= '0;
         rd_hold_q   <= '0;
         ack_q       <= 1'b0;
         rd_data_q   <= '0;
         tx_push_q   <= 1'b0;
         tx_data_q   <= '0;
         rx_pop_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         txen_q      <= txen_d;
         nstop_q     <= nstop_d;
         rxen_q      <= rxen_d;
         txcnt_q     <= txcnt_d;
         rxcnt_q     <= rxcnt_d;
         ie_q        <= ie_d;
         div_q       <= div_d;
         lcr_q       <= lcr_d;
         err_q       <= err_d;
         push_pend_q <= push_pend_d;
         pend_data_q <= pend_data_d;
         rd_hold_q   <= rd_hold_d;
         ack_q       <= ack_d;
         rd_data_q   <= rd_data_d;
         tx_push_q   <= tx_push_d;
         tx_data_q   <= tx_data_d;
         rx_pop_q    <= rx_pop_d;
         irq_q       <= irq_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign ack        = ack_q;
   assign interrupt  = irq_q;
   assign txen       = txen_q;
   assign rxen       = rxen_q;
   assign nstop      = nstop_q;
   assign parity_en  = lcr_q[0];
   assign parity_odd = lcr_q[1];
   assign div        = div_q;
   assign txcnt      = txcnt_q;
   assign rxcnt      = rxcnt_q;
   assign tx_push    = tx_push_q;
   assign tx_data    = tx_data_q;
   assign rx_pop     = rx_pop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_bank_v2.sv
`default_nettype none
// tb_uart_bank_v2: directed self-checking bench for uart_bank_v2 (default parameters, CW = 3).
module tb_uart_bank_v2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0, we = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        ack, interrupt, txen, rxen, nstop, parity_en, parity_odd;
   logic [15:0] div;
   logic [2:0]  txcnt, rxcnt;
   logic        tx_push, rx_pop;
   logic [7:0]  tx_data;
   logic        tx_full = 1'b0;
   logic [3:0]  tx_level = '0, rx_level = '0;
   logic [7:0]  rx_data = '0;
   logic        rx_empty = 1'b1;
   logic        rx_frame_err = 1'b0, rx_parity_err = 1'b0, rx_overrun = 1'b0;
   logic [7:0]  rx_fifo_byte = '0;

   int nvec = 0;
   int nerr = 0;

   uart_bank_v2 dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
      .rd_data(rd_data), .ack(ack), .interrupt(interrupt), .txen(txen), .rxen(rxen),
      .nstop(nstop), .parity_en(parity_en), .parity_odd(parity_odd), .div(div),
      .txcnt(txcnt), .rxcnt(rxcnt), .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
      .tx_level(tx_level), .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty),
      .rx_level(rx_level), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
      .rx_overrun(rx_overrun)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One bus access; called and returns 1 time unit after a rising edge.
   // The RX FIFO model only presents rx_fifo_byte on rx_data after a pop edge.
   task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input bit par_pulse, output logic [31:0] rd, output int lat,
                      output int pushes, output int pops, output logic [7:0] pdata);
      bit pop_prev = 1'b0;
      pushes = 0; pops = 0; lat = -1; rd = '0; pdata = '0;
      we = w; addr = a; wr_data = d; req = 1'b1;
      if (par_pulse) rx_parity_err = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clock); #1;
         rx_parity_err = 1'b0;
         if (pop_prev) rx_data = rx_fifo_byte;
         pop_prev = rx_pop;
         if (rx_pop) pops++;
         if (tx_push) begin pushes++; pdata = tx_data; end
         if (ack) begin lat = c; rd = rd_data; req = 1'b0; break; end
      end
      if (lat < 0) begin
         nvec++; nerr++;
         $display("FAIL bus_timeout addr=%0d: no ack within 20 cycles", a);
         req = 1'b0;
      end
      @(posedge clock); #1;
      if (rx_pop) pops++;
      if (tx_push) begin pushes++; pdata = tx_data; end
      nvec++;
      if (ack !== 1'b0) begin nerr++; $display("FAIL ack_single addr=%0d: ack=%b, expected 0", a, ack); end
   endtask

   task automatic test_reset();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      @(posedge clock); @(posedge clock); #1;
      nvec++;
      if (div !== 16'd86) begin nerr++; $display("FAIL reset_div: got %0d expected 86", div); end
      nvec++;
      if ({ack, interrupt, tx_push, rx_pop, rd_data} !== 36'd0) begin nerr++;
         $display("FAIL reset_outputs: got %h expected 0", {ack, interrupt, tx_push, rx_pop, rd_data}); end
      nvec++;
      if ({txen, rxen, nstop, parity_en, parity_odd, txcnt, rxcnt} !== 11'd0) begin nerr++;
         $display("FAIL reset_csr_outputs: got %h expected 0", {txen, rxen, nstop, parity_en, parity_odd, txcnt, rxcnt}); end
      @(posedge clock); #1; reset = 1'b0;
      bus(1'b0, 4'd6, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h56) begin nerr++; $display("FAIL read_div: got %h expected 00000056", rd); end
      nvec++;
      if (lat !== 2) begin nerr++; $display("FAIL read_div_latency: got %0d expected 2", lat); end
      bus(1'b0, 4'd8, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0) begin nerr++; $display("FAIL reset_err: got %h expected 0", rd); end
   endtask

   task automatic test_csr();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      bus(1'b1, 4'd7, 32'h3, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if ({parity_odd, parity_en} !== 2'b11) begin nerr++; $display("FAIL lcr_outputs: got %b expected 11", {parity_odd, parity_en}); end
      bus(1'b1, 4'd2, 32'h0005_0003, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if ({txcnt, nstop, txen} !== 5'b101_1_1) begin nerr++; $display("FAIL txctrl_outputs: got %b expected 10111", {txcnt, nstop, txen}); end
      bus(1'b0, 4'd2, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0005_0003) begin nerr++; $display("FAIL txctrl_read: got %h expected 00050003", rd); end
      tx_level = 4'd3; rx_level = 4'd5;
      bus(1'b0, 4'd9, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0005_0003) begin nerr++; $display("FAIL level_read: got %h expected 00050003", rd); end
      tx_level = 4'd0; rx_level = 4'd0;
      bus(1'b1, 4'd12, 32'hFFFF_FFFF, 1'b0, rd, lat, pu, po, pd);
      bus(1'b0, 4'd12, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0 || lat !== 2) begin nerr++; $display("FAIL unmapped_read: got %h lat %0d expected 0 lat 2", rd, lat); end
      bus(1'b1, 4'd2, 32'h0, 1'b0, rd, lat, pu, po, pd);
   endtask

   task automatic test_txdata();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      tx_full = 1'b0;
      bus(1'b1, 4'd0, 32'h0000_12A5, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (pu !== 1 || pd !== 8'hA5) begin nerr++; $display("FAIL tx_push: got %0d pushes data %h expected 1 A5", pu, pd); end
      tx_full = 1'b1;
      bus(1'b1, 4'd0, 32'h0000_0011, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (pu !== 0) begin nerr++; $display("FAIL tx_full_push: got %0d pushes expected 0", pu); end
      bus(1'b0, 4'd8, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h8) begin nerr++; $display("FAIL tx_drop_err: got %h expected 00000008", rd); end
      bus(1'b0, 4'd0, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h8000_0000 || pu !== 0) begin nerr++; $display("FAIL txdata_read: got %h pushes %0d expected 80000000 0", rd, pu); end
      tx_full = 1'b0;
      bus(1'b1, 4'd8, 32'h8, 1'b0, rd, lat, pu, po, pd);
      bus(1'b0, 4'd8, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0) begin nerr++; $display("FAIL err_w1c_txdrop: got %h expected 0", rd); end
   endtask

   task automatic test_rxdata();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      rx_empty = 1'b0; rx_data = 8'h00; rx_fifo_byte = 8'h3C;
      bus(1'b0, 4'd1, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0000_003C) begin nerr++; $display("FAIL rxdata_value: got %h expected 0000003C", rd); end
      nvec++;
      if (po !== 1 || lat !== 4) begin nerr++; $display("FAIL rxdata_pop: got pops %0d lat %0d expected 1 4", po, lat); end
      rx_empty = 1'b1;
      bus(1'b0, 4'd1, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h8000_0000 || po !== 0 || lat !== 2) begin nerr++;
         $display("FAIL rxdata_empty: got %h pops %0d lat %0d expected 80000000 0 2", rd, po, lat); end
   endtask

   task automatic test_interrupt();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      rx_level = 4'd1;
      bus(1'b1, 4'd4, 32'h2, 1'b0, rd, lat, pu, po, pd);
      bus(1'b1, 4'd3, 32'h0001_0001, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (interrupt !== 1'b0 || rxen !== 1'b1 || rxcnt !== 3'd1) begin nerr++;
         $display("FAIL irq_setup: got irq %b rxen %b rxcnt %0d expected 0 1 1", interrupt, rxen, rxcnt); end
      rx_level = 4'd2;
      @(negedge clock);
      nvec++;
      if (interrupt !== 1'b0) begin nerr++; $display("FAIL irq_latency_rise: got %b expected 0 before edge", interrupt); end
      @(posedge clock); #1;
      nvec++;
      if (interrupt !== 1'b1) begin nerr++; $display("FAIL irq_rise: got %b expected 1", interrupt); end
      bus(1'b0, 4'd5, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h2) begin nerr++; $display("FAIL ip_read: got %h expected 00000002", rd); end
      rx_level = 4'd1;
      @(negedge clock);
      nvec++;
      if (interrupt !== 1'b1) begin nerr++; $display("FAIL irq_latency_fall: got %b expected 1 before edge", interrupt); end
      @(posedge clock); #1;
      nvec++;
      if (interrupt !== 1'b0) begin nerr++; $display("FAIL irq_fall: got %b expected 0", interrupt); end
   endtask

   task automatic test_err_w1c();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      rx_parity_err = 1'b1;
      @(posedge clock); #1;
      rx_parity_err = 1'b0;
      bus(1'b0, 4'd8, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h2) begin nerr++; $display("FAIL err_parity_set: got %h expected 00000002", rd); end
      bus(1'b1, 4'd8, 32'h2, 1'b1, rd, lat, pu, po, pd);
      bus(1'b0, 4'd8, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h2) begin nerr++; $display("FAIL err_set_wins: got %h expected 00000002", rd); end
      bus(1'b1, 4'd8, 32'h2, 1'b0, rd, lat, pu, po, pd);
      bus(1'b0, 4'd8, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'h0) begin nerr++; $display("FAIL err_clear: got %h expected 0", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; int lat, pu, po; logic [7:0] pd;
      int acks = 0, pops = 0;
      rx_empty = 1'b0; we = 1'b0; addr = 4'd1; req = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1; req = 1'b0;
      #1;
      nvec++;
      if (ack !== 1'b0 || rx_pop !== 1'b0 || interrupt !== 1'b0) begin nerr++;
         $display("FAIL reset_mid_outputs: got ack %b pop %b irq %b expected 0 0 0", ack, rx_pop, interrupt); end
      @(posedge clock); #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1;
         if (ack) acks++;
         if (rx_pop) pops++;
      end
      nvec++;
      if (acks !== 0 || pops !== 0) begin nerr++; $display("FAIL reset_mid_no_ack: got acks %0d pops %0d expected 0 0", acks, pops); end
      rx_empty = 1'b1;
      bus(1'b1, 4'd6, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (div !== 16'd86) begin nerr++; $display("FAIL div_zero_ignored: got %0d expected 86", div); end
      bus(1'b1, 4'd6, 32'h000A_000A, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (div !== 16'd10) begin nerr++; $display("FAIL div_write: got %0d expected 10", div); end
      bus(1'b0, 4'd6, 32'h0, 1'b0, rd, lat, pu, po, pd);
      nvec++;
      if (rd !== 32'hA) begin nerr++; $display("FAIL div_read: got %h expected 0000000A", rd); end
   endtask

   initial begin
      test_reset();
      test_csr();
      test_txdata();
      test_rxdata();
      test_interrupt();
      test_err_w1c();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
